// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide over operand magnitudes, one bit
// per cycle. Signs are restored when the result is written to hi/lo.
// Optional feature macro: MDU_ABORT_EN (adds the 'abort' input).
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_hi;   // product upper half / partial remainder / raw a on b==0
  logic [WIDTH-1:0] r_acc_lo;   // multiplier -> product lower half / dividend -> quotient
  logic [WIDTH-1:0] r_b;        // |b|
  logic             r_div;
  logic             r_zero;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_abort;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_neg;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

`ifdef MDU_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_signed = op[0];
  assign w_a_mag  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    w_sum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
    w_sh      = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_neg     = (w_sh < {1'b0, r_b});
    w_diff    = w_sh[WIDTH-1:0] - r_b;
    w_step_hi = '0;
    w_step_lo = '0;
    if (r_div) begin
      w_step_hi = w_neg ? w_sh[WIDTH-1:0] : w_diff;
      w_step_lo = {r_acc_lo[WIDTH-2:0], ~w_neg};
    end else begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Final sign restoration and result selection for hi/lo.
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_neg_q) begin
      w_prod = ~w_prod + 1'b1;
    end
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_zero) begin
      w_res_hi = r_acc_hi;
      w_res_lo = '1;
    end else if (r_div) begin
      w_res_hi = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;
      w_res_lo = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
    end
  end

  // Control FSM, datapath registers and HI/LO.
  // FIN spends one cycle writing hi/lo (done=1) and one cycle releasing busy,
  // so the b==0 shortcut and the iterative path share the same tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_dz   <= 1'b0;
          if (start) begin
            r_busy   <= 1'b1;
            r_div    <= op[1];
            r_neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= op[0] & a[WIDTH-1];
            r_b      <= w_b_mag;
            r_acc_lo <= w_a_mag;
            r_cnt    <= '0;
            if (op[1] && (b == '0)) begin
              r_zero   <= 1'b1;
              r_acc_hi <= a;
              r_state  <= ST_FIN;
            end else begin
              r_zero   <= 1'b0;
              r_acc_hi <= '0;
              r_state  <= ST_CALC;
            end
          end else begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        ST_CALC: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          if (!r_done) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
            r_dz   <= r_zero;
          end else begin
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed results for mul_div_unit.
// Build with +define+MDU_ABORT_EN to exercise the abort port.
`timescale 1ns/1ps
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
`ifdef MDU_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_chk;
  int unsigned n_pass;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  mul_div_unit #(.WIDTH(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
`ifdef MDU_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; returns 1ns after the accepting edge (edge 0).
  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
  endtask

  // From just after edge 0: expect busy=1/done=0 up to edge lat-1, result at
  // edge lat, busy released at edge lat+1. poke!=0 re-pulses start before that edge.
  task automatic run_op(input string tag, input int unsigned lat, input int unsigned poke,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    logic bad;
    bad = 1'b0;
    for (int unsigned k = 1; k < lat; k++) begin
      if (k == poke) begin
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd3;
      end
      tick();
      start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1 || div_by_zero !== 1'b0) bad = 1'b1;
    end
    tick();
    chk({tag, "_busy_window"}, {63'd0, bad}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
    chk({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
    chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    tick();
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
`ifdef MDU_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_in", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("reset_after", {29'd0, busy, done, div_by_zero, hi}, 64'd0);

    // 1. MULTU 0xFFFFFFFF * 2
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_busy_e0", {63'd0, busy}, 64'd1);
    a = 32'h0; b = 32'h0;
    run_op("multu", 33, 0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

    // 2. Signed multiply and truncating divide
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("mult_neg", 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_neg", 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("div_negb", 33, 0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    // 3. Divide by zero and the overflow case
    launch(OP_DIVU, 32'd100, 32'd0);
    run_op("divu_zero", 1, 0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf", 33, 0, 32'h0, 32'h8000_0000, 1'b0);

    // 4. Direct HI/LO writes
    @(negedge clk); mthi = 1'b1; a = 32'h1234;
    tick(); mthi = 1'b0;
    @(negedge clk); mtlo = 1'b1; a = 32'h5678;
    tick(); mtlo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});

    launch(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk); mthi = 1'b1; a = 32'hDEAD; b = 32'hBEEF;
    tick(); mthi = 1'b0;
    chk("mthi_busy_ignored", {32'd0, hi}, 64'h1234);
    run_op("mul_after_mthi", 32, 0, 32'h0, 32'd12, 1'b0);

    @(negedge clk);
    start = 1'b1; mtlo = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0; mtlo = 1'b0;
    chk("start_beats_mtlo", {31'd0, busy, lo}, {31'd0, 1'b1, 32'd12});
    run_op("mul_6x7", 33, 0, 32'h0, 32'd42, 1'b0);

    // 5. Start while busy is ignored; asynchronous reset mid-op
    launch(OP_DIVU, 32'd50, 32'd5);
    run_op("divu_restart_ignored", 33, 10, 32'h0, 32'd10, 1'b0);

    @(negedge clk); mthi = 1'b1; a = 32'h55;
    tick(); mthi = 1'b0;
    launch(OP_DIVU, 32'd50, 32'd5);
    repeat (14) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_op", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
    chk("rst_mid_op_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int unsigned k = 0; k < 40; k++) begin
        tick();
        if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      chk("rst_op_lost", {63'd0, seen}, 64'd0);
    end

    // 6. Abort (when built in) versus run to completion
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; a = 32'hAAAA;
    tick(); mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {32'hAAAA, 32'hAAAA});
`ifdef MDU_ABORT_EN
    launch(OP_MULTU, 32'd3, 32'd4);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {62'd0, busy, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, {32'hAAAA, 32'hAAAA});
    begin
      logic seen;
      seen = 1'b0;
      for (int unsigned k = 0; k < 36; k++) begin
        tick();
        if (done !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_done", {63'd0, seen}, 64'd0);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_wins", {63'd0, busy}, 64'd1);
    run_op("mul_5x5", 33, 0, 32'h0, 32'd25, 1'b0);
`else
    launch(OP_MULTU, 32'd3, 32'd4);
    run_op("mul_no_abort", 33, 0, 32'h0, 32'd12, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
